// File: rtl/conv_mem_if_pkg.sv
// rtl/conv_mem_if_pkg.sv - channel indices and width helper for the conv memory interface
package conv_mem_if_pkg;

  localparam int CH_IN_FM  = 0;
  localparam int CH_WEIGHT = 1;
  localparam int CH_OUT_LD = 2;
  localparam int CH_OUT_ST = 3;

  // Count must hold the value DEPTH itself, hence depth+1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// rtl/conv_sync_fifo.sv - single-clock FIFO channel with occupancy, flush and sticky error flags
module conv_sync_fifo
  import conv_mem_if_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 256,
  parameter int AF_THRESH  = 240,
  parameter int SHOW_AHEAD = 1,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic [CW-1:0] count_o,
  input  logic          flush_i,
  input  logic          err_clr_i,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, af_q, ovf_q, unf_q;
  logic          push_acc, pop_acc, push_rej, pop_rej;

  // Flush swallows both requests on its cycle, so neither can raise an error flag.
  always_comb begin
    pop_acc  = pop_i & ~flush_i & ~empty_q;
    push_acc = push_i & ~flush_i & (~full_q | pop_acc);
    push_rej = push_i & ~flush_i & ~push_acc;
    pop_rej  = pop_i & ~flush_i & empty_q;
    count_d  = count_q + {{(CW-1){1'b0}}, push_acc} - {{(CW-1){1'b0}}, pop_acc};
    if (flush_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_acc) wptr_q <= wptr_q + 1'b1;
        if (pop_acc)  rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
      af_q    <= (count_d >= AF_CNT);
      ovf_q   <= push_rej | (ovf_q & ~err_clr_i);
      unf_q   <= pop_rej | (unf_q & ~err_clr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wptr_q] <= din_i;
  end

  if (SHOW_AHEAD != 0) begin : g_fwft
    assign dout_o = empty_q ? '0 : mem_q[rptr_q];
  end else begin : g_reg
    logic [DW-1:0] dout_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        dout_q <= '0;
      end else if (pop_acc) begin
        dout_q <= mem_q[rptr_q];
      end
    end
    assign dout_o = dout_q;
  end

  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign count_o       = count_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

// File: rtl/conv_mem_if_multi.sv
// rtl/conv_mem_if_multi.sv - NUM_CH independent FIFOs between the DDR loader/storer and conv_core
module conv_mem_if_multi
  import conv_mem_if_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 256,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = 240,
  parameter int SHOW_AHEAD = 1,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_CH-1:0]    push_i,
  input  logic [NUM_CH*DW-1:0] din_i,
  input  logic [NUM_CH-1:0]    pop_i,
  output logic [NUM_CH*DW-1:0] dout_o,
  output logic [NUM_CH-1:0]    empty_o,
  output logic [NUM_CH-1:0]    full_o,
  output logic [NUM_CH-1:0]    almost_full_o,
  output logic [NUM_CH*CW-1:0] count_o,
  input  logic [NUM_CH-1:0]    flush_i,
  input  logic                 err_clr_i,
  output logic [NUM_CH-1:0]    overflow_o,
  output logic [NUM_CH-1:0]    underflow_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    conv_sync_fifo #(
      .DW         (DW),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF_THRESH),
      .SHOW_AHEAD (SHOW_AHEAD)
    ) u_fifo (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .push_i        (push_i[i]),
      .din_i         (din_i[i*DW +: DW]),
      .pop_i         (pop_i[i]),
      .dout_o        (dout_o[i*DW +: DW]),
      .empty_o       (empty_o[i]),
      .full_o        (full_o[i]),
      .almost_full_o (almost_full_o[i]),
      .count_o       (count_o[i*CW +: CW]),
      .flush_i       (flush_i[i]),
      .err_clr_i     (err_clr_i),
      .overflow_o    (overflow_o[i]),
      .underflow_o   (underflow_o[i])
    );
  end

endmodule

// File: tb/tb_conv_mem_if_multi.sv
// tb/tb_conv_mem_if_multi.sv - scoreboard bench for a show-ahead and a registered-read instance
module tb_conv_mem_if_multi;
  import conv_mem_if_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  logic [3:0]   push_v [2];
  logic [3:0]   pop_v [2];
  logic [3:0]   flush_v [2];
  logic         err_v [2];
  logic [127:0] din_v [2];

  logic [127:0] dout0, dout1;
  logic [3:0]   empty0, full0, af0, ovf0, unf0;
  logic [3:0]   empty1, full1, af1, ovf1, unf1;
  logic [35:0]  count0;
  logic [19:0]  count1;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;

  logic [31:0] mq [2][4][$];
  logic        mov [2][4];
  logic        mun [2][4];
  logic [31:0] mlast [2][4];

  always #5 clk = ~clk;

  conv_mem_if_multi #(.DW(32), .DEPTH(256), .NUM_CH(4), .AF_THRESH(240), .SHOW_AHEAD(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .push_i(push_v[0]), .din_i(din_v[0]), .pop_i(pop_v[0]),
    .dout_o(dout0), .empty_o(empty0), .full_o(full0), .almost_full_o(af0), .count_o(count0),
    .flush_i(flush_v[0]), .err_clr_i(err_v[0]), .overflow_o(ovf0), .underflow_o(unf0)
  );

  conv_mem_if_multi #(.DW(32), .DEPTH(16), .NUM_CH(4), .AF_THRESH(12), .SHOW_AHEAD(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .push_i(push_v[1]), .din_i(din_v[1]), .pop_i(pop_v[1]),
    .dout_o(dout1), .empty_o(empty1), .full_o(full1), .almost_full_o(af1), .count_o(count1),
    .flush_i(flush_v[1]), .err_clr_i(err_v[1]), .overflow_o(ovf1), .underflow_o(unf1)
  );

  // Reference model: one queue per channel, updated from the inputs seen at each edge.
  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        int depth;
        int sz;
        bit pa, wa;
        depth = (d == 0) ? 256 : 16;
        if (!rst_ni) begin
          mq[d][c].delete();
          mov[d][c] = 1'b0;
          mun[d][c] = 1'b0;
          mlast[d][c] = '0;
        end else if (flush_v[d][c]) begin
          mq[d][c].delete();
          if (err_v[d]) begin
            mov[d][c] = 1'b0;
            mun[d][c] = 1'b0;
          end
        end else begin
          sz = mq[d][c].size();
          pa = pop_v[d][c] && (sz > 0);
          wa = push_v[d][c] && ((sz < depth) || pa);
          mov[d][c] = (push_v[d][c] && !wa) || (mov[d][c] && !err_v[d]);
          mun[d][c] = (pop_v[d][c] && (sz == 0)) || (mun[d][c] && !err_v[d]);
          if (pa) mlast[d][c] = mq[d][c].pop_front();
          if (wa) mq[d][c].push_back(din_v[d][c*32 +: 32]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d ch%0d t=%0t got=%h exp=%h", nm, d, c, $time, act, exp);
    end
  endtask

  // Monitor: compares every channel's outputs against the model away from the active edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin
          logic [31:0] a_dout, a_cnt, e_dout;
          logic a_e, a_f, a_af, a_ov, a_un;
          int sz;
          int depth;
          int thr;
          sz = mq[d][c].size();
          if (d == 0) begin
            depth = 256; thr = 240;
            a_dout = dout0[c*32 +: 32]; a_cnt = 32'(count0[c*9 +: 9]);
            a_e = empty0[c]; a_f = full0[c]; a_af = af0[c]; a_ov = ovf0[c]; a_un = unf0[c];
            e_dout = (sz > 0) ? mq[d][c][0] : 32'h0;
          end else begin
            depth = 16; thr = 12;
            a_dout = dout1[c*32 +: 32]; a_cnt = 32'(count1[c*5 +: 5]);
            a_e = empty1[c]; a_f = full1[c]; a_af = af1[c]; a_ov = ovf1[c]; a_un = unf1[c];
            e_dout = mlast[d][c];
          end
          chk("dout", d, c, a_dout, e_dout);
          chk("count", d, c, a_cnt, 32'(sz));
          chk("empty", d, c, 32'(a_e), 32'(sz == 0));
          chk("full", d, c, 32'(a_f), 32'(sz == depth));
          chk("almost_full", d, c, 32'(a_af), 32'(sz >= thr));
          chk("overflow", d, c, 32'(a_ov), 32'(mov[d][c]));
          chk("underflow", d, c, 32'(a_un), 32'(mun[d][c]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      push_v[d] = '0; pop_v[d] = '0; flush_v[d] = '0; err_v[d] = 1'b0; din_v[d] = '0;
    end
  endtask

  task automatic op(input int d, input int c, input bit p, input bit q, input logic [31:0] data,
                    input bit f, input bit e);
    clr();
    push_v[d][c] = p;
    pop_v[d][c] = q;
    flush_v[d][c] = f;
    err_v[d] = e;
    din_v[d][c*32 +: 32] = data;
    cyc();
    clr();
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) cyc();
  endtask

  task automatic rand_traffic(input int n, input int pp, input int pq);
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin
          push_v[d][c]  = ($urandom_range(0, 99) < pp);
          pop_v[d][c]   = ($urandom_range(0, 99) < pq);
          flush_v[d][c] = ($urandom_range(0, 99) < 1);
          din_v[d][c*32 +: 32] = $urandom;
        end
        err_v[d] = ($urandom_range(0, 99) < 2);
      end
      cyc();
    end
    clr();
  endtask

  initial begin
    clr();
    rst_ni = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Fill and drain in show-ahead mode
    for (int i = 0; i < 256; i++) op(0, CH_IN_FM, 1, 0, 32'(i), 0, 0);
    idle(1);
    for (int i = 0; i < 256; i++) op(0, CH_IN_FM, 0, 1, 32'h0, 0, 0);
    idle(1);

    // Overflow on a full channel, underflow on an empty one, then clear
    for (int i = 0; i < 256; i++) op(0, CH_WEIGHT, 1, 0, $urandom, 0, 0);
    op(0, CH_WEIGHT, 1, 0, 32'hDEAD, 0, 0);
    for (int i = 0; i < 256; i++) op(0, CH_WEIGHT, 0, 1, 32'h0, 0, 0);
    op(0, CH_OUT_LD, 0, 1, 32'h0, 0, 0);
    idle(1);
    op(0, CH_OUT_LD, 0, 0, 32'h0, 0, 1);
    idle(1);

    // Simultaneous push and pop at full and at empty
    for (int i = 0; i < 256; i++) op(0, CH_OUT_ST, 1, 0, 32'(i + 1000), 0, 0);
    op(0, CH_OUT_ST, 1, 1, 32'hBEEF, 0, 0);
    for (int i = 0; i < 256; i++) op(0, CH_OUT_ST, 0, 1, 32'h0, 0, 0);
    op(0, CH_OUT_ST, 1, 1, 32'h1234, 0, 0);
    op(0, CH_OUT_ST, 0, 1, 32'h0, 0, 0);
    op(0, CH_OUT_ST, 0, 1, 32'h0, 0, 1);
    op(0, CH_OUT_ST, 0, 0, 32'h0, 0, 1);
    idle(1);

    // Registered-read instance: data appears after the pop and holds while idle
    op(1, 0, 1, 0, 32'hA, 0, 0);
    op(1, 0, 1, 0, 32'hB, 0, 0);
    op(1, 0, 0, 1, 32'h0, 0, 0);
    idle(5);
    op(1, 0, 0, 1, 32'h0, 0, 0);
    idle(2);

    // Pointer wrap across three rounds, then flush with a concurrent push
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) op(1, 1, 1, 0, 32'(r * 100 + i), 0, 0);
      for (int i = 0; i < 12; i++) op(1, 1, 0, 1, 32'h0, 0, 0);
    end
    for (int i = 0; i < 5; i++) op(1, 1, 1, 0, 32'(i + 50), 0, 0);
    op(1, 1, 1, 0, 32'h77, 1, 0);
    op(1, 1, 1, 0, 32'h1, 0, 0);
    op(1, 1, 0, 1, 32'h0, 0, 0);
    idle(2);

    // Random traffic with a reset pulse in the middle
    rand_traffic(800, 70, 30);
    rand_traffic(400, 50, 50);
    for (int d = 0; d < 2; d++) begin
      push_v[d] = 4'hF; pop_v[d] = 4'hF; din_v[d] = {$urandom, $urandom, $urandom, $urandom};
    end
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    clr();
    idle(1);
    rand_traffic(800, 65, 35);
    rand_traffic(600, 30, 70);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
